mdu_core: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
- Executes the MDU operations that the decoder selects with MDUEN/MDUCtrl: mult, multu, div, divu, mthi, mtlo.
- Exposes a registered Busy flag; the hazard unit uses it to stall mfhi/mflo and any new MDU operation.
- Adds configurable data width, independent multiply and divide latencies, and a cancel input so the exception/flush logic can abort an in-flight operation.

---
 rtl/mdu_core_if.sv | 26 ++
 rtl/mdu_core.sv | 143 ++++++++++++++
 tb/tb_mdu_core.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_core_if.sv
`timescale 1ns/1ps
// Request/result bundle between the E stage and the multiply/divide unit.
// A request (MDUEN with MDUCtrl/A/B) is taken on a rising edge only while Busy=0 and cancel=0; Busy=1 is the "not ready" signal, and a request that meets Busy=1 is dropped, not held.
interface mdu_core_if #(
   parameter int WIDTH = 32
);
   logic             MDUEN;
   logic [2:0]       MDUCtrl;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             cancel;
   logic             Busy;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic             dbg_state;

   modport master (
      output MDUEN, MDUCtrl, A, B, cancel,
      input  Busy, HI, LO, dbg_state
   );

   modport slave (
      input  MDUEN, MDUCtrl, A, B, cancel,
      output Busy, HI, LO, dbg_state
   );
endinterface

// File: rtl/mdu_core.sv
`timescale 1ns/1ps
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// One latched op runs for a fixed cycle count, then commits to HI/LO unless cancelled.
module mdu_core #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       rst_n,
   mdu_core_if.slave bus
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] hi_q, lo_q, hi_n, lo_n;
   logic             start;

   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic               is_sdiv, a_neg, b_neg, b_zero;
   logic [WIDTH-1:0]   mag_a, mag_b, div_a, div_b;
   logic [WIDTH-1:0]   quo_u, rem_u, quo, rem;

   assign start = (state == IDLE) && bus.MDUEN && !bus.cancel &&
                  (bus.MDUCtrl >= OP_MULT) && (bus.MDUCtrl <= OP_DIVU);

   // Arithmetic works only on the operands latched at the start edge.
   assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
   assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

   // Signed divide goes through magnitudes; the most-negative magnitude wraps to itself,
   // so MIN / -1 yields quotient MIN and remainder 0 with no special case.
   assign is_sdiv = (op_q == OP_DIV);
   assign a_neg   = a_q[WIDTH-1];
   assign b_neg   = b_q[WIDTH-1];
   assign b_zero  = (b_q == '0);
   assign mag_a   = a_neg ? ({WIDTH{1'b0}} - a_q) : a_q;
   assign mag_b   = b_neg ? ({WIDTH{1'b0}} - b_q) : b_q;
   assign div_a   = is_sdiv ? mag_a : a_q;
   assign div_b   = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : (is_sdiv ? mag_b : b_q);
   assign quo_u   = div_a / div_b;
   assign rem_u   = div_a % div_b;
   assign quo     = (is_sdiv && (a_neg ^ b_neg)) ? ({WIDTH{1'b0}} - quo_u) : quo_u;
   assign rem     = (is_sdiv && a_neg) ? ({WIDTH{1'b0}} - rem_u) : rem_u;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      hi_n    = hi_q;
      lo_n    = lo_q;
      case (state)
         IDLE: begin
            if (bus.MDUEN && !bus.cancel) begin
               case (bus.MDUCtrl)
                  OP_MULT, OP_MULTU: begin
                     state_n = RUN;
                     cnt_n   = CW'(MULT_CYCLES);
                  end
                  OP_DIV, OP_DIVU: begin
                     state_n = RUN;
                     cnt_n   = CW'(DIV_CYCLES);
                  end
                  OP_MTHI: hi_n = bus.A;
                  OP_MTLO: lo_n = bus.A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (bus.cancel) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == CW'(1)) begin
               state_n = IDLE;
               cnt_n   = '0;
               case (op_q)
                  OP_MULT: begin
                     hi_n = prod_s[2*WIDTH-1:WIDTH];
                     lo_n = prod_s[WIDTH-1:0];
                  end
                  OP_MULTU: begin
                     hi_n = prod_u[2*WIDTH-1:WIDTH];
                     lo_n = prod_u[WIDTH-1:0];
                  end
                  OP_DIV, OP_DIVU: begin
                     if (!b_zero) begin
                        hi_n = rem;
                        lo_n = quo;
                     end
                  end
                  default: ;
               endcase
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         hi_q  <= hi_n;
         lo_q  <= lo_n;
         if (start) begin
            op_q <= bus.MDUCtrl;
            a_q  <= bus.A;
            b_q  <= bus.B;
         end
      end
   end

   assign bus.Busy      = (state == RUN);
   assign bus.HI        = hi_q;
   assign bus.LO        = lo_q;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_mdu_core.sv
`timescale 1ns/1ps
// Bench for mdu_core: directed vectors plus random ops against an arithmetic model,
// on a 32-bit/5/10 instance and a 16-bit/1/3 instance.
module tb_mdu_core;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [31:0] m_hi[2];
   logic [31:0] m_lo[2];

   mdu_core_if #(.WIDTH(32)) bus ();
   mdu_core_if #(.WIDTH(16)) bus16 ();

   mdu_core #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   mdu_core #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit w16, input logic en, input logic [2:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b, input logic cn);
      if (w16) begin
         bus16.MDUEN = en; bus16.MDUCtrl = ctrl; bus16.A = a[15:0]; bus16.B = b[15:0]; bus16.cancel = cn;
      end else begin
         bus.MDUEN = en; bus.MDUCtrl = ctrl; bus.A = a; bus.B = b; bus.cancel = cn;
      end
   endtask

   function automatic logic rd_busy(input bit w16);
      return w16 ? bus16.Busy : bus.Busy;
   endfunction

   function automatic logic [31:0] rd_hi(input bit w16);
      return w16 ? {16'd0, bus16.HI} : bus.HI;
   endfunction

   function automatic logic [31:0] rd_lo(input bit w16);
      return w16 ? {16'd0, bus16.LO} : bus.LO;
   endfunction

   function automatic int exp_cycles(input bit w16, input logic [2:0] op);
      if (op == 3'd1 || op == 3'd2) return w16 ? 1 : 5;
      if (op == 3'd3 || op == 3'd4) return w16 ? 3 : 10;
      return 0;
   endfunction

   function automatic longint sext(input logic [31:0] v, input bit w16);
      logic [15:0] v16;
      v16 = v[15:0];
      if (w16) return longint'($signed(v16));
      return longint'($signed(v));
   endfunction

   // Reference: plain 64-bit arithmetic (SV / and % truncate toward zero).
   task automatic ref_op(input bit w16, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, inout logic [31:0] hi, inout logic [31:0] lo);
      logic [31:0] mask;
      longint      sa, sb, p;
      logic [63:0] ua, ub, pu;
      int          w;
      w    = w16 ? 16 : 32;
      mask = w16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      sa   = sext(a, w16);
      sb   = sext(b, w16);
      ua   = {32'd0, a & mask};
      ub   = {32'd0, b & mask};
      case (op)
         3'd1: begin p = sa * sb; lo = 32'(p) & mask; hi = 32'(p >>> w) & mask; end
         3'd2: begin pu = ua * ub; lo = pu[31:0] & mask; hi = 32'(pu >> w) & mask; end
         3'd3: if (ub != 0) begin lo = 32'(sa / sb) & mask; hi = 32'(sa % sb) & mask; end
         3'd4: if (ub != 0) begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
         3'd5: hi = a & mask;
         3'd6: lo = a & mask;
         default: ;
      endcase
   endtask

   // Issue one request for one edge, then count busy cycles (bounded) and sample HI/LO.
   task automatic run_op(input bit w16, input logic en, input logic [2:0] ctrl,
                         input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic [31:0] hi, output logic [31:0] lo);
      drive(w16, en, ctrl, a, b, 1'b0);
      step();
      drive(w16, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      n = 0;
      while (rd_busy(w16) && n < 60) begin
         n++;
         step();
      end
      hi = rd_hi(w16);
      lo = rd_lo(w16);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      #3;
      total++;
      if ({bus.Busy, bus.dbg_state, bus.HI, bus.LO} !== 66'd0) begin
         bad++; $display("FAIL reset32: busy=%b st=%b hi=%h lo=%h want all 0", bus.Busy, bus.dbg_state, bus.HI, bus.LO);
      end
      total++;
      if ({bus16.Busy, bus16.HI, bus16.LO} !== 33'd0) begin
         bad++; $display("FAIL reset16: busy=%b hi=%h lo=%h want all 0", bus16.Busy, bus16.HI, bus16.LO);
      end
      step();
      rst_n = 1'b1;
      step();
      m_hi[0] = 0; m_lo[0] = 0; m_hi[1] = 0; m_lo[1] = 0;
   endtask

   task automatic test_mult();
      int n; logic [31:0] hi, lo;
      run_op(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5, n, hi, lo);
      ref_op(1'b0, 3'd1, 32'hFFFF_FFFD, 32'd5, m_hi[0], m_lo[0]);
      total++;
      if (n !== 5) begin bad++; $display("FAIL mult_busy: got %0d want 5", n); end
      total++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL mult_res: got %h_%h want ffffffff_fffffff1", hi, lo); end
      run_op(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFD, 32'd5, n, hi, lo);
      ref_op(1'b0, 3'd2, 32'hFFFF_FFFD, 32'd5, m_hi[0], m_lo[0]);
      total++;
      if (n !== 5) begin bad++; $display("FAIL multu_busy: got %0d want 5", n); end
      total++;
      if ({hi, lo} !== 64'h0000_0004_FFFF_FFF1) begin bad++; $display("FAIL multu_res: got %h_%h want 00000004_fffffff1", hi, lo); end
   endtask

   task automatic test_div();
      int n; logic [31:0] hi, lo;
      run_op(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, n, hi, lo);
      ref_op(1'b0, 3'd3, 32'hFFFF_FFF9, 32'd2, m_hi[0], m_lo[0]);
      total++;
      if (n !== 10) begin bad++; $display("FAIL div_busy: got %0d want 10", n); end
      total++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg: got %h_%h want ffffffff_fffffffd", hi, lo); end
      run_op(1'b0, 1'b1, 3'd4, 32'd7, 32'd2, n, hi, lo);
      ref_op(1'b0, 3'd4, 32'd7, 32'd2, m_hi[0], m_lo[0]);
      total++;
      if ({hi, lo} !== 64'h0000_0001_0000_0003) begin bad++; $display("FAIL divu_res: got %h_%h want 00000001_00000003", hi, lo); end
      run_op(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n, hi, lo);
      ref_op(1'b0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, m_hi[0], m_lo[0]);
      total++;
      if ({hi, lo} !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_ovf: got %h_%h want 00000000_80000000", hi, lo); end
   endtask

   task automatic test_moves_divzero();
      int n; logic [31:0] hi, lo;
      run_op(1'b0, 1'b1, 3'd5, 32'h1234_5678, 32'd0, n, hi, lo);
      ref_op(1'b0, 3'd5, 32'h1234_5678, 32'd0, m_hi[0], m_lo[0]);
      total++;
      if (n !== 0 || hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi: busy=%0d hi=%h want 0 12345678", n, hi); end
      run_op(1'b0, 1'b1, 3'd6, 32'hAAAA_0000, 32'd0, n, hi, lo);
      ref_op(1'b0, 3'd6, 32'hAAAA_0000, 32'd0, m_hi[0], m_lo[0]);
      total++;
      if (n !== 0 || lo !== 32'hAAAA_0000) begin bad++; $display("FAIL mtlo: busy=%0d lo=%h want 0 aaaa0000", n, lo); end
      run_op(1'b0, 1'b1, 3'd4, 32'd9, 32'd0, n, hi, lo);
      total++;
      if (n !== 10) begin bad++; $display("FAIL divz_busy: got %0d want 10", n); end
      total++;
      if ({hi, lo} !== 64'h1234_5678_AAAA_0000) begin bad++; $display("FAIL divz_keep: got %h_%h want 12345678_aaaa0000", hi, lo); end
   endtask

   task automatic test_back_to_back();
      int n; logic [31:0] hi, lo;
      drive(1'b0, 1'b1, 3'd1, 32'd7, 32'd6, 1'b0);
      step();
      n = 0;
      while (bus.Busy && n < 60) begin
         n++;
         if (n[0]) drive(1'b0, 1'b1, 3'd6, 32'h0000_DEAD, 32'd0, 1'b0);
         else      drive(1'b0, 1'b1, 3'd1, 32'd1, 32'd1, 1'b0);
         step();
      end
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      ref_op(1'b0, 3'd1, 32'd7, 32'd6, m_hi[0], m_lo[0]);
      total++;
      if (n !== 5) begin bad++; $display("FAIL lock_busy: got %0d want 5", n); end
      total++;
      if ({bus.HI, bus.LO} !== 64'd42) begin bad++; $display("FAIL lock_res: got %h_%h want 00000000_0000002a", bus.HI, bus.LO); end
      run_op(1'b0, 1'b1, 3'd4, 32'd100, 32'd7, n, hi, lo);
      ref_op(1'b0, 3'd4, 32'd100, 32'd7, m_hi[0], m_lo[0]);
      total++;
      if (n !== 10 || {hi, lo} !== {32'd2, 32'd14}) begin
         bad++; $display("FAIL b2b_divu: busy=%0d got %h_%h want 10 00000002_0000000e", n, hi, lo);
      end
   endtask

   task automatic test_cancel();
      drive(1'b0, 1'b1, 3'd1, 32'd123, 32'd456, 1'b0);
      step();
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      step(); step();
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      step();
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      total++;
      if (bus.Busy !== 1'b0 || bus.dbg_state !== 1'b0) begin bad++; $display("FAIL cancel_busy: busy=%b st=%b want 0 0", bus.Busy, bus.dbg_state); end
      step(); step(); step();
      total++;
      if ({bus.HI, bus.LO} !== {m_hi[0], m_lo[0]}) begin bad++; $display("FAIL cancel_keep: got %h_%h want %h_%h", bus.HI, bus.LO, m_hi[0], m_lo[0]); end
      drive(1'b0, 1'b1, 3'd2, 32'd99, 32'd99, 1'b0);
      step();
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      repeat (4) step();
      total++;
      if (bus.Busy !== 1'b1) begin bad++; $display("FAIL last_cycle_busy: got %b want 1", bus.Busy); end
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      step();
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      total++;
      if ({bus.Busy, bus.HI, bus.LO} !== {1'b0, m_hi[0], m_lo[0]}) begin
         bad++; $display("FAIL cancel_commit: busy=%b got %h_%h want 0 %h_%h", bus.Busy, bus.HI, bus.LO, m_hi[0], m_lo[0]);
      end
      drive(1'b0, 1'b1, 3'd5, 32'h5555_5555, 32'd0, 1'b1);
      step();
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      total++;
      if (bus.HI !== m_hi[0]) begin bad++; $display("FAIL cancel_idle: hi=%h want %h", bus.HI, m_hi[0]); end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 3'd3, 32'd1000, 32'd3, 1'b0);
      step();
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.Busy, bus.HI, bus.LO} !== 65'd0) begin
         bad++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h want all 0", bus.Busy, bus.HI, bus.LO);
      end
      step();
      rst_n = 1'b1;
      step();
      m_hi[0] = 0; m_lo[0] = 0; m_hi[1] = 0; m_lo[1] = 0;
      total++;
      if ({bus.Busy, bus.HI, bus.LO} !== 65'd0) begin
         bad++; $display("FAIL reset_hold: busy=%b hi=%h lo=%h want all 0", bus.Busy, bus.HI, bus.LO);
      end
   endtask

   task automatic test_sweep16();
      int n; logic [31:0] hi, lo;
      run_op(1'b1, 1'b1, 3'd1, 32'h8000, 32'h8000, n, hi, lo);
      ref_op(1'b1, 3'd1, 32'h8000, 32'h8000, m_hi[1], m_lo[1]);
      total++;
      if (n !== 1 || hi !== 32'h4000 || lo !== 32'h0) begin bad++; $display("FAIL w16_mult: busy=%0d got %h_%h want 1 4000_0000", n, hi[15:0], lo[15:0]); end
      run_op(1'b1, 1'b1, 3'd4, 32'hFFFF, 32'h0010, n, hi, lo);
      ref_op(1'b1, 3'd4, 32'hFFFF, 32'h0010, m_hi[1], m_lo[1]);
      total++;
      if (n !== 3 || hi !== 32'h000F || lo !== 32'h0FFF) begin bad++; $display("FAIL w16_divu: busy=%0d got %h_%h want 3 000f_0fff", n, hi[15:0], lo[15:0]); end
   endtask

   task automatic test_random(input bit w16, input int count);
      int n, exp_n;
      logic [31:0] hi, lo, a, b;
      logic [2:0]  op;
      logic        en;
      for (int i = 0; i < count; i++) begin
         op = 3'($urandom_range(0, 7));
         en = ($urandom_range(0, 9) != 0);
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = w16 ? 32'h8000 : 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 9);
            default: ;
         endcase
         exp_n = en ? exp_cycles(w16, op) : 0;
         run_op(w16, en, op, a, b, n, hi, lo);
         if (en) ref_op(w16, op, a, b, m_hi[w16], m_lo[w16]);
         total++;
         if (n !== exp_n) begin bad++; $display("FAIL rand_busy w16=%0d op=%0d: got %0d want %0d", w16, op, n, exp_n); end
         total++;
         if ({hi, lo} !== {m_hi[w16], m_lo[w16]}) begin
            bad++; $display("FAIL rand_res w16=%0d op=%0d en=%b a=%h b=%h: got %h_%h want %h_%h",
                            w16, op, en, a, b, hi, lo, m_hi[w16], m_lo[w16]);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_mult();
      test_div();
      test_moves_divzero();
      test_back_to_back();
      test_cancel();
      test_sweep16();
      test_random(1'b1, 40);
      test_reset_mid();
      test_random(1'b0, 60);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
